fifo_word_packer: RTL and testbench

Read-side consumer for the team's synchronous byte FIFO. It pops `Width`-bit entries from the FIFO read port, packs `Lanes` consecutive entries into one word, and presents that word on a valid/ready output stream. A `flush` request forces out a partial word with a lane-keep mask. The block sits directly downstream of the FIFO and drives its `rd_en`.

---
 rtl/fifo_word_packer.sv | 123 ++++++++++++
 tb/tb_fifo_word_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Packs Lanes consecutive FIFO entries into one output word on a valid/ready
// stream. Drives the FIFO pop directly (1-cycle read latency) and supports a
// flush that forces out a partial word with a lane-keep mask.
module fifo_word_packer #(
  parameter int Width = 8,
  parameter int Lanes = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [Width-1:0]       fifo_data_out,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Width*Lanes-1:0] out_data,
  output logic [Lanes-1:0]       out_keep
);

  localparam int CW = $clog2(Lanes + 1);

  typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [Width-1:0]       acc_q [Lanes];
  logic [Width-1:0]       acc_d [Lanes];
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [Width*Lanes-1:0] out_data_q, out_data_d;
  logic [Lanes-1:0]       out_keep_q, out_keep_d;
  logic                   out_valid_q, out_valid_d;

  logic          slot_free;
  logic          xfer;
  logic          emit_load;
  logic [CW-1:0] base;
  logic [CW:0]   fill;

  // A full accumulator moves out whenever the output slot can take it; the
  // landing lane index and the read-gating fill level are taken after that move.
  assign slot_free  = !out_valid_q || out_ready;
  assign xfer       = (cnt_q == CW'(Lanes)) && slot_free;
  assign base       = xfer ? '0 : cnt_q;
  assign fill       = {1'b0, base} + (CW+1)'(pend_q);
  assign emit_load  = (state_q == EMIT) && (cnt_q != '0) && slot_free;
  assign flush_done = (state_q == EMIT) && ((cnt_q == '0) || slot_free);
  // Only pop when the entry is guaranteed a free lane on landing.
  assign fifo_rd_en = rst_n && (state_q == RUN) && !fifo_empty &&
                      (fill < (CW+1)'(Lanes));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

  // Next state: RUN accepts a flush, DRAIN waits out in-flight entries and
  // full words, EMIT pushes the partial word (or nothing) and returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (!pend_q && (cnt_q < CW'(Lanes))) state_d = EMIT;
      EMIT:    if ((cnt_q == '0) || slot_free) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Accumulator fill: landing entry goes into the next free lane.
  always_comb begin
    acc_d  = acc_q;
    pend_d = fifo_rd_en;
    for (int i = 0; i < Lanes; i++) begin
      if (pend_q && (base == CW'(i))) acc_d[i] = fifo_data_out;
    end
    if (emit_load) cnt_d = '0;
    else           cnt_d = base + CW'(pend_q);
  end

  // Output register: full-word load, partial-word load, or clear on handshake.
  always_comb begin
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      for (int i = 0; i < Lanes; i++) out_data_d[i*Width +: Width] = acc_q[i];
      out_keep_d  = '1;
      out_valid_d = 1'b1;
    end else if (emit_load) begin
      for (int i = 0; i < Lanes; i++) begin
        out_data_d[i*Width +: Width] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
        out_keep_d[i]                = (CW'(i) < cnt_q);
      end
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Accumulator storage; contents are qualified by cnt, so no reset needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural FIFO feeding the packer,
// output-handshake monitor, and one task per scenario.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    int          cyc;
  } word_t;

  logic [7:0] fq[$];
  word_t      cap[$];
  int         cyc = 0;
  int         rd_count = 0;
  int         underflow = 0;
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         tests = 0;
  int         fails = 0;

  fifo_word_packer #(.Width(8), .Lanes(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .flush_done    (flush_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO read port with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_count++;
      if (fq.size() == 0) underflow++;
      else fifo_data_out <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Output handshake and flush_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) cap.push_back('{out_data, out_keep, cyc});
      if (flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_mon();
    cap.delete();
    fd_cnt = 0;
    rd_count = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cap.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    tests++; if (out_keep !== 4'h0) begin fails++; $display("FAIL reset_out_keep got %h exp 0", out_keep); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
    do_reset();
  endtask

  task automatic test_basic_pack();
    bit ok;
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_words(1, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got %0d words exp 1", cap.size()); end
    repeat (10) @(posedge clk); #1;
    tests++; if (cap.size() != 1) begin fails++; $display("FAIL basic_count got %0d exp 1", cap.size()); end
    if (cap.size() >= 1) begin
      tests++; if (cap[0].data !== 32'h44332211) begin fails++; $display("FAIL basic_data got %h exp 44332211", cap[0].data); end
      tests++; if (cap[0].keep !== 4'hF) begin fails++; $display("FAIL basic_keep got %h exp f", cap[0].keep); end
    end
    tests++; if (rd_count != 4) begin fails++; $display("FAIL basic_pops got %0d exp 4", rd_count); end
  endtask

  task automatic test_streaming();
    bit ok;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504;
    exp_w[2] = 32'h0B0A0908; exp_w[3] = 32'h0F0E0D0C;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    wait_words(4, 60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stream_timeout got %0d words exp 4", cap.size()); end
    repeat (10) @(posedge clk); #1;
    tests++; if (cap.size() != 4) begin fails++; $display("FAIL stream_count got %0d exp 4", cap.size()); end
    for (int k = 0; k < 4 && k < cap.size(); k++) begin
      tests++; if (cap[k].data !== exp_w[k]) begin fails++; $display("FAIL stream_word%0d got %h exp %h", k, cap[k].data, exp_w[k]); end
      if (k > 0) begin
        tests++; if (cap[k].cyc - cap[k-1].cyc != 5) begin fails++; $display("FAIL stream_gap%0d got %0d exp 5", k, cap[k].cyc - cap[k-1].cyc); end
      end
    end
    tests++; if (rd_count != 16 || underflow != 0) begin fails++; $display("FAIL stream_pops got %0d/%0d exp 16/0", rd_count, underflow); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'h20 + 8'(i));
    repeat (30) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 32'h23222120) begin fails++; $display("FAIL bp_data got %h exp 23222120", out_data); end
    tests++; if (rd_count != 8) begin fails++; $display("FAIL bp_pops got %0d exp 8", rd_count); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en got %b exp 0", fifo_rd_en); end
    repeat (5) @(posedge clk); #1;
    tests++; if (out_data !== 32'h23222120 || out_keep !== 4'hF) begin fails++; $display("FAIL bp_stable got %h/%h exp 23222120/f", out_data, out_keep); end
    out_ready = 1'b1;
    wait_words(3, 30, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got %0d words exp 3", cap.size()); end
    if (cap.size() >= 3) begin
      tests++; if (cap[0].data !== 32'h23222120) begin fails++; $display("FAIL bp_word0 got %h exp 23222120", cap[0].data); end
      tests++; if (cap[1].data !== 32'h27262524) begin fails++; $display("FAIL bp_word1 got %h exp 27262524", cap[1].data); end
      tests++; if (cap[2].data !== 32'h2B2A2928) begin fails++; $display("FAIL bp_word2 got %h exp 2b2a2928", cap[2].data); end
    end
  endtask

  task automatic test_partial_flush();
    bit ok;
    do_reset();
    push_byte(8'hAA); push_byte(8'hBB);
    repeat (6) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_words(1, 10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pflush_timeout got %0d words exp 1", cap.size()); end
    repeat (4) @(posedge clk); #1;
    tests++; if (fd_cnt != 1) begin fails++; $display("FAIL pflush_done_count got %0d exp 1", fd_cnt); end
    if (cap.size() >= 1) begin
      tests++; if (cap[0].data !== 32'h0000BBAA) begin fails++; $display("FAIL pflush_data got %h exp 0000bbaa", cap[0].data); end
      tests++; if (cap[0].keep !== 4'h3) begin fails++; $display("FAIL pflush_keep got %h exp 3", cap[0].keep); end
      tests++; if (cap[0].cyc != fd_cyc + 1) begin fails++; $display("FAIL pflush_align got word@%0d done@%0d exp word one after done", cap[0].cyc, fd_cyc); end
    end
  endtask

  task automatic test_empty_flush();
    int c0;
    do_reset();
    repeat (2) @(posedge clk); #1;
    c0 = cyc;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (8) @(posedge clk); #1;
    tests++; if (fd_cnt != 1) begin fails++; $display("FAIL eflush_done_count got %0d exp 1", fd_cnt); end
    tests++; if (fd_cnt == 1 && (fd_cyc - c0 > 2 || fd_cyc - c0 < 1)) begin fails++; $display("FAIL eflush_latency got %0d exp 1..2", fd_cyc - c0); end
    tests++; if (cap.size() != 0 || out_valid !== 1'b0) begin fails++; $display("FAIL eflush_no_word got %0d words exp 0", cap.size()); end
  endtask

  task automatic test_flush_last_lane();
    do_reset();
    push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    repeat (4) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (15) @(posedge clk); #1;
    tests++; if (cap.size() != 1) begin fails++; $display("FAIL lastlane_count got %0d exp 1", cap.size()); end
    if (cap.size() >= 1) begin
      tests++; if (cap[0].data !== 32'hC3C2C1C0 || cap[0].keep !== 4'hF) begin fails++; $display("FAIL lastlane_word got %h/%h exp c3c2c1c0/f", cap[0].data, cap[0].keep); end
      tests++; if (fd_cnt != 1 || fd_cyc <= cap[0].cyc) begin fails++; $display("FAIL lastlane_done got %0d@%0d exp 1 after %0d", fd_cnt, fd_cyc, cap[0].cyc); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_byte(8'h60); push_byte(8'h61);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rmid_rd_en got %b exp 0", fifo_rd_en); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0 || out_keep !== 4'h0) begin fails++; $display("FAIL rmid_out got %h/%h exp 0/0", out_data, out_keep); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    push_byte(8'h70); push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    wait_words(1, 20, ok);
    repeat (8) @(posedge clk); #1;
    tests++; if (!ok || cap.size() != 1) begin fails++; $display("FAIL rmid_count got %0d exp 1", cap.size()); end
    if (cap.size() >= 1) begin
      tests++; if (cap[0].data !== 32'h73727170 || cap[0].keep !== 4'hF) begin fails++; $display("FAIL rmid_word got %h/%h exp 73727170/f", cap[0].data, cap[0].keep); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_streaming();
    test_backpressure();
    test_partial_flush();
    test_empty_flush();
    test_flush_last_lane();
    test_reset_mid();
    tests++; if (underflow != 0) begin fails++; $display("FAIL fifo_underflow got %0d exp 0", underflow); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
